seg_scan_bcd_driver: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 45 ++++
 rtl/bcd_dabble_seq.sv | 74 +++++++
 rtl/seg_scan_bcd_driver.sv | 144 ++++++++++++++
 tb/tb_seg_scan_bcd_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared glyphs, converter state encoding and sizing helper for the
// multiplexed BCD 7-segment driver. Segment order is {dp,g,f,e,d,c,b,a}, active low.
package seg_scan_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_COMMIT
  } conv_state_t;

  // Bit width of the BCD field holding one nibble per display digit.
  function automatic int unsigned bcd_nibbles(input int unsigned digits);
    return 4 * digits;
  endfunction

  function automatic logic [7:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// done is high for the single COMMIT cycle; start is accepted in IDLE or COMMIT.
module bcd_dabble_seq
  import seg_scan_pkg::*;
#(
  parameter int unsigned VAL_W  = 16,
  parameter int unsigned DIGITS = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [VAL_W-1:0]               bin,
  output logic                           busy,
  output logic                           done,
  output logic [bcd_nibbles(DIGITS)-1:0] bcd,
  output logic                           ovf
);

  localparam int unsigned BCD_W = bcd_nibbles(DIGITS);
  localparam int unsigned CNT_W = $clog2(VAL_W);

  conv_state_t      state, state_nxt;
  logic [VAL_W-1:0] bin_sr;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] adj;
  logic             load_now;

  assign load_now = start && (state == CONV_IDLE || state == CONV_COMMIT);
  assign busy     = (state != CONV_IDLE);
  assign done     = (state == CONV_COMMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CONV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CONV_IDLE:   if (start) state_nxt = CONV_SHIFT;
      CONV_SHIFT:  if (cnt == CNT_W'(VAL_W - 1)) state_nxt = CONV_COMMIT;
      CONV_COMMIT: state_nxt = start ? CONV_SHIFT : CONV_IDLE;
      default:     state_nxt = CONV_IDLE;
    endcase
  end

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Anything leaving the top nibble means the value needs more digits than exist.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr <= '0;
      bcd    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (load_now) begin
      bin_sr <= bin;
      bcd    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (state == CONV_SHIFT) begin
      bcd    <= {adj[BCD_W-2:0], bin_sr[VAL_W-1]};
      bin_sr <= {bin_sr[VAL_W-2:0], 1'b0};
      cnt    <= cnt + 1'b1;
      if (adj[BCD_W-1]) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_bcd_driver.sv
// Multiplexed active-low common-anode N-digit driver with on-board binary-to-BCD
// conversion, leading-zero blanking, dot and overflow dash. Option: SEG_SCAN_BLINK_EN.
module seg_scan_bcd_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned VAL_W     = 16,
  parameter int unsigned SCAN_CYC  = 1000,
  parameter int unsigned BLINK_CYC = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VAL_W-1:0]  din,
  input  logic              load,
  input  logic [3:0]        dot_pos,
  input  logic              lz_blank,
  output logic              busy,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        dig
`ifdef SEG_SCAN_BLINK_EN
  ,
  input  logic [DIGITS-1:0] blink_mask
`endif
);

  localparam int unsigned BCD_W  = bcd_nibbles(DIGITS);
  localparam int unsigned SCAN_W = $clog2(SCAN_CYC);

  logic              conv_start, conv_busy, conv_done, conv_ovf;
  logic [VAL_W-1:0]  conv_bin, pend_val;
  logic [BCD_W-1:0]  conv_bcd, buf_bcd;
  logic              pend_valid, buf_ovf;
  logic [SCAN_W-1:0] scan_cnt;
  logic [3:0]        cur_nib;
  logic [7:0]        seg_nxt;
  logic              blank_cur, blink_hide;
  int unsigned       cur_idx, hi_idx, dot_idx;

  // A fresh load beats the pending value; restart straight out of COMMIT keeps busy high.
  assign conv_start = (!conv_busy || conv_done) && (load || pend_valid);
  assign conv_bin   = load ? din : pend_val;
  assign busy       = conv_busy;

  bcd_dabble_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_val   <= '0;
      buf_bcd    <= '0;
      buf_ovf    <= 1'b0;
    end else begin
      if (conv_start) pend_valid <= 1'b0;
      else if (load) begin
        pend_valid <= 1'b1;
        pend_val   <= din;
      end
      if (conv_done) begin
        buf_bcd <= conv_bcd;
        buf_ovf <= conv_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= {1'b0, {(DIGITS-1){1'b1}}};
      dig      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_CYC - 1)) begin
        scan_cnt <= '0;
        sel      <= {sel[0], sel[DIGITS-1:1]};
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      dig <= seg_nxt;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_CYC);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    blink_hide = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!sel[i] && blink_mask[i] && !blink_phase) blink_hide = 1'b1;
    end
  end
`else
  assign blink_hide = 1'b0 && (BLINK_CYC != 0);
`endif

  always_comb begin
    cur_idx = 0;
    hi_idx  = 0;
    cur_nib = '0;
    dot_idx = {28'd0, dot_pos};
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!sel[i]) begin
        cur_idx = i;
        cur_nib = buf_bcd[4*i +: 4];
      end
      if (buf_bcd[4*i +: 4] != 4'd0) hi_idx = i;
    end
    blank_cur = lz_blank && (cur_idx != 0) && (cur_idx > hi_idx) &&
                !((dot_idx < DIGITS) && (cur_idx <= dot_idx));
    if (buf_ovf) begin
      seg_nxt = SEG_DASH;
    end else begin
      seg_nxt = blank_cur ? SEG_BLANK : seg_glyph(cur_nib);
      if (cur_idx == dot_idx) seg_nxt[7] = 1'b0;
    end
    if (blink_hide) seg_nxt = SEG_BLANK;
  end

endmodule

// File: tb/tb_seg_scan_bcd_driver.sv
// Scoreboard bench for seg_scan_bcd_driver: a 6-digit and a 4-digit instance,
// expected display contents come from a decimal model of each loaded value.
module tb_seg_scan_bcd_driver;

  localparam int VW = 16;
  localparam int SC = 8;
  localparam int BC = 8;

  typedef struct {
    int val;
    int dot;
    bit lz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din_a, din_b;
  logic        load_a, load_b, lz_a, lz_b, busy_a, busy_b;
  logic [3:0]  dot_a, dot_b;
  logic [5:0]  sel_a;
  logic [3:0]  sel_b;
  logic [7:0]  dig_a, dig_b;
`ifdef SEG_SCAN_BLINK_EN
  logic [5:0]  bm_a;
  logic [3:0]  bm_b;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   run_a = 0, last_a = 0, run_b = 0, last_b = 0;
  int   cyc = 0;
  bit   mon200 = 1'b0, saw200 = 1'b0;
  logic [5:0] psel_a = '1;

  always #5 clk = ~clk;

  seg_scan_bcd_driver #(.DIGITS(6), .VAL_W(VW), .SCAN_CYC(SC), .BLINK_CYC(BC)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .load(load_a), .dot_pos(dot_a),
    .lz_blank(lz_a), .busy(busy_a), .sel(sel_a), .dig(dig_a)
`ifdef SEG_SCAN_BLINK_EN
    , .blink_mask(bm_a)
`endif
  );

  seg_scan_bcd_driver #(.DIGITS(4), .VAL_W(VW), .SCAN_CYC(SC), .BLINK_CYC(BC)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .load(load_b), .dot_pos(dot_b),
    .lz_blank(lz_b), .busy(busy_b), .sel(sel_b), .dig(dig_b)
`ifdef SEG_SCAN_BLINK_EN
    , .blink_mask(bm_b)
`endif
  );

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (busy_a) run_a++;
    else if (run_a != 0) begin last_a = run_a; run_a = 0; end
    if (busy_b) run_b++;
    else if (run_b != 0) begin last_b = run_b; run_b = 0; end
    if (mon200 && psel_a == 6'b111011 && dig_a == 8'hA4) saw200 = 1'b1;
    psel_a = sel_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_dig(input int val, input int digits, input int k,
                                           input int dot, input bit lz);
    int p = 1;
    int hi = 0;
    int dd[8];
    logic [7:0] g;
    for (int i = 0; i < digits; i++) begin
      dd[i] = (val / p) % 10;
      if (dd[i] != 0) hi = i;
      p = p * 10;
    end
    if (val >= p) return 8'hBF;
    if (lz && k > 0 && k > hi && !(dot < digits && k <= dot)) g = 8'hFF;
    else g = glyph(dd[k]);
    if (k == dot) g[7] = 1'b0;
    return g;
  endfunction

  task automatic do_load(input bit on_b, input int val, input int dot, input bit lz);
    exp_t e;
    e.val = val; e.dot = dot; e.lz = lz;
    if (!on_b) begin
      din_a = 16'(val); dot_a = 4'(dot); lz_a = lz; load_a = 1'b1;
      if (busy_a && sb_a.size() >= 2) sb_a[sb_a.size()-1] = e;
      else sb_a.push_back(e);
    end else begin
      din_b = 16'(val); dot_b = 4'(dot); lz_b = lz; load_b = 1'b1;
      if (busy_b && sb_b.size() >= 2) sb_b[sb_b.size()-1] = e;
      else sb_b.push_back(e);
    end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic get_dig(input bit on_b, input int k, output logic [7:0] d);
    bit prev = 1'b0;
    bit hit = 1'b0;
    logic [5:0] ma;
    logic [3:0] mb;
    ma = ~(6'd1 << k);
    mb = ~(4'd1 << k);
    d = 8'h00;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (on_b ? (sel_b == mb) : (sel_a == ma)) begin
        if (prev) begin d = on_b ? dig_b : dig_a; hit = 1'b1; end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
    if (!hit) check($sformatf("scan_timeout k%0d", k), 32'd0, 32'd1);
  endtask

  task automatic drain(input bit on_b);
    int n = 0;
    int cnt;
    int digits;
    exp_t e;
    logic [7:0] d;
    digits = on_b ? 4 : 6;
    while ((on_b ? busy_b : busy_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("busy_end", 32'(on_b ? busy_b : busy_a), 32'd0);
    if (on_b) begin cnt = sb_b.size(); e = sb_b[cnt-1]; sb_b.delete(); end
    else      begin cnt = sb_a.size(); e = sb_a[cnt-1]; sb_a.delete(); end
    check($sformatf("busy_len v%0d", e.val), 32'(on_b ? last_b : last_a), 32'(cnt * (VW + 1)));
    for (int k = 0; k < digits; k++) begin
      get_dig(on_b, k, d);
      check($sformatf("dig%0d v%0d", k, e.val), 32'(d), 32'(model_dig(e.val, digits, k, e.dot, e.lz)));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] ex;
    din_a = '0; din_b = '0; load_a = 1'b0; load_b = 1'b0;
    dot_a = 4'd15; dot_b = 4'd15; lz_a = 1'b1; lz_b = 1'b1;
`ifdef SEG_SCAN_BLINK_EN
    bm_a = '0; bm_b = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_sel_a", 32'(sel_a), 32'h1F);
    check("rst_sel_b", 32'(sel_b), 32'h7);
    check("rst_dig", 32'(dig_a), 32'hFF);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    repeat (SC - 1) @(negedge clk);
    check("scan_hold", 32'(sel_a), 32'h1F);
    @(negedge clk);
    check("scan_rot", 32'(sel_a), 32'h2F);

    do_load(0, 1234, 15, 1'b1);  drain(0);
    din_a = 16'd9999;
    repeat (5) @(negedge clk);
    get_dig(0, 0, d);
    check("din_ignored", 32'(d), 32'h99);
    do_load(0, 5, 2, 1'b1);      drain(0);
    do_load(0, 7, 4, 1'b1);      drain(0);
    do_load(0, 0, 15, 1'b0);     drain(0);
    do_load(0, 0, 15, 1'b1);     drain(0);
    do_load(0, 65535, 15, 1'b1); drain(0);

    saw200 = 1'b0;
    mon200 = 1'b1;
    do_load(0, 100, 15, 1'b1);
    @(negedge clk);
    do_load(0, 200, 15, 1'b1);
    do_load(0, 300, 15, 1'b1);
    drain(0);
    mon200 = 1'b0;
    check("never_200", 32'(saw200), 32'd0);

    do_load(0, 999, 15, 1'b1);
    repeat (2) @(negedge clk);
    do_load(0, 555, 15, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_a.delete();
    check("abort_busy", 32'(busy_a), 32'd0);
    repeat (40) @(negedge clk);
    check("no_restart", 32'(busy_a), 32'd0);
    for (int k = 0; k < 6; k++) begin
      get_dig(0, k, d);
      check($sformatf("cleared dig%0d", k), 32'(d), 32'(model_dig(0, 6, k, 15, 1'b1)));
    end

    do_load(1, 12345, 15, 1'b1); drain(1);
    do_load(1, 42, 15, 1'b1);    drain(1);
    do_load(1, 9999, 15, 1'b1);  drain(1);

`ifdef SEG_SCAN_BLINK_EN
    do_load(0, 1234, 15, 1'b1);  drain(0);
    bm_a = 6'b000001;
    begin
      logic [5:0] ps;
      ps = sel_a;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (ps == 6'b111110 && sel_a == 6'b111110) begin
          ex = (((cyc - 1) / BC) % 2 == 1) ? 8'hFF : model_dig(1234, 6, 0, 15, 1'b1);
          check($sformatf("blink0 c%0d", cyc), 32'(dig_a), 32'(ex));
        end
        if (ps == 6'b111101 && sel_a == 6'b111101)
          check($sformatf("blink1 c%0d", cyc), 32'(dig_a), 32'(model_dig(1234, 6, 1, 15, 1'b1)));
        ps = sel_a;
      end
    end
    bm_a = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
